// File: rtl/rd_burst_pkg.sv
// Shared types and helpers for the read-side burst planner.
package rd_burst_pkg;

    // Planner FSM states.
    typedef enum logic [2:0] {
        IDLE,
        CALC,
        WAIT_SPACE,
        REQ,
        WAIT_DONE,
        FRAME_END
    } state_t;

    // Bytes per beat at the default 256-bit AXI data width.
    localparam int AXI_DSIZE_DEF = 256;
    localparam int BB            = AXI_DSIZE_DEF / 8;

    // Beats needed to carry one line: ceil(hactive*dsize / axi_dsize),
    // formed with a 32-bit intermediate so wide lines cannot overflow.
    function automatic logic [15:0] ceil_beats(input logic [15:0] hactive,
                                               input int          dsize,
                                               input int          axi_dsize);
        logic [31:0] bits;
        bits = 32'(hactive) * 32'(dsize) + 32'(axi_dsize - 1);
        return 16'(bits >> $clog2(axi_dsize));
    endfunction

endpackage

// File: rtl/rd_burst_planner_splitter.sv
// Splits one line's beat count into bursts of at most BURST_LEN beats.
module burst_len_splitter
    import rd_burst_pkg::*;
#(
    parameter int LSIZE     = 9,
    parameter int BURST_LEN = 200
) (
    input  logic             axi_aclk,
    input  logic             axi_resetn,
    input  logic             load,
    input  logic [15:0]      line_beats_in,
    input  logic             step,
    output logic [LSIZE-1:0] cur_len,
    output logic             line_end
);

    logic [15:0] line_beats_q;
    logic [15:0] beats_left;

    // Current burst is the full size unless only a shorter tail remains.
    always_comb begin
        cur_len = LSIZE'(BURST_LEN);
        if (beats_left < 16'(BURST_LEN)) begin
            cur_len = LSIZE'(beats_left);
        end
    end

    // The current burst finishes the line when it covers every remaining beat.
    assign line_end = (beats_left <= 16'(BURST_LEN));

    // Track beats left in the line; reload the line length after the tail burst.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            line_beats_q <= '0;
            beats_left   <= '0;
        end else if (load) begin
            line_beats_q <= line_beats_in;
            beats_left   <= line_beats_in;
        end else if (step) begin
            if (line_end) begin
                beats_left <= line_beats_q;
            end else begin
                beats_left <= beats_left - 16'(cur_len);
            end
        end
    end

endmodule

// File: rtl/rd_burst_planner.sv
// Read-side request planner: turns a frame start and the video geometry into
// a sequence of single-outstanding burst requests gated by stream-FIFO room.
module rd_burst_planner
    import rd_burst_pkg::*;
#(
    parameter int ASIZE       = 29,
    parameter int LSIZE       = 9,
    parameter int BURST_LEN   = 200,
    parameter int FULL_LEN    = 512,
    parameter int CSIZE       = 10,
    parameter int AXI_DSIZE   = 256,
    parameter int DSIZE       = 24,
    parameter int LINE_STRIDE = 8192
) (
    input  logic             axi_aclk,
    input  logic             axi_resetn,
    input  logic             enable,
    input  logic             fsync,
    input  logic [ASIZE-1:0] baseaddr,
    input  logic [15:0]      hactive,
    input  logic [15:0]      vactive,
    input  logic [CSIZE-1:0] fifo_count,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [ASIZE-1:0] req_addr,
    output logic [LSIZE-1:0] req_len,
    input  logic             req_done,
    output logic             busy,
    output logic             frame_done
);

    localparam int BEAT_BYTES = AXI_DSIZE / 8;

    state_t             state;
    state_t             state_n;
    logic [15:0]        hact_q;
    logic [15:0]        vact_q;
    logic [15:0]        line_cnt;
    logic [ASIZE-1:0]   line_addr;
    logic [ASIZE-1:0]   addr;
    logic [ASIZE-1:0]   next_line_addr;
    logic [LSIZE-1:0]   cur_len;
    logic [15:0]        line_beats_c;
    logic               line_end;
    logic               line_last;
    logic               calc;
    logic               step;
    logic               issue;
    logic signed [31:0] space;
    logic               has_room;

    assign line_beats_c   = ceil_beats(hact_q, DSIZE, AXI_DSIZE);
    assign next_line_addr = line_addr + ASIZE'(LINE_STRIDE);
    assign line_last      = line_end && ((line_cnt + 16'd1) == vact_q);

    // Free FIFO space must strictly exceed the burst, keeping one beat spare.
    assign space    = $signed(32'(FULL_LEN)) - $signed(32'(fifo_count));
    assign has_room = (space > $signed(32'(cur_len)));

    assign busy       = (state != IDLE);
    assign frame_done = (state == FRAME_END);

    burst_len_splitter #(
        .LSIZE     (LSIZE),
        .BURST_LEN (BURST_LEN)
    ) u_splitter (
        .axi_aclk      (axi_aclk),
        .axi_resetn    (axi_resetn),
        .load          (calc),
        .line_beats_in (line_beats_c),
        .step          (step),
        .cur_len       (cur_len),
        .line_end      (line_end)
    );

    // State register.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and datapath strobes; a frame start overrides everything.
    always_comb begin
        state_n = state;
        calc    = 1'b0;
        step    = 1'b0;
        issue   = 1'b0;
        case (state)
            IDLE: state_n = IDLE;
            CALC: begin
                calc    = 1'b1;
                state_n = (hact_q == '0 || vact_q == '0) ? FRAME_END : WAIT_SPACE;
            end
            WAIT_SPACE: begin
                if (enable && has_room) begin
                    issue   = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (req_ready) begin
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (req_done) begin
                    step    = 1'b1;
                    state_n = line_last ? FRAME_END : WAIT_SPACE;
                end
            end
            FRAME_END: state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        if (fsync) begin
            state_n = CALC;
            calc    = 1'b0;
            step    = 1'b0;
            issue   = 1'b0;
        end
    end

    // Geometry latch plus line/burst address walk.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            hact_q    <= '0;
            vact_q    <= '0;
            line_cnt  <= '0;
            line_addr <= '0;
            addr      <= '0;
        end else if (fsync) begin
            hact_q    <= hactive;
            vact_q    <= vactive;
            line_cnt  <= '0;
            line_addr <= baseaddr;
            addr      <= baseaddr;
        end else if (step) begin
            if (line_end) begin
                line_cnt  <= line_cnt + 16'd1;
                line_addr <= next_line_addr;
                addr      <= next_line_addr;
            end else begin
                addr <= addr + ASIZE'(cur_len) * ASIZE'(BEAT_BYTES);
            end
        end
    end

    // Registered request outputs, held stable while waiting for req_ready.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            req_valid <= 1'b0;
            req_addr  <= '0;
            req_len   <= '0;
        end else begin
            req_valid <= (state_n == REQ);
            if (issue) begin
                req_addr <= addr;
                req_len  <= cur_len;
            end
        end
    end

endmodule

// File: tb/tb_rd_burst_planner.sv
// Bench for rd_burst_planner: two instances (BURST_LEN 64 and 200) share the
// frame inputs; requests are logged and compared with a line/burst model.
module tb_rd_burst_planner;

    localparam int ASIZE = 29;
    localparam int LSIZE = 9;
    localparam int CSIZE = 10;
    localparam int BL0   = 64;
    localparam int BL1   = 200;

    typedef struct packed {
        logic             inst;
        logic [ASIZE-1:0] addr;
        logic [LSIZE-1:0] len;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             enable;
    logic             fsync;
    logic [ASIZE-1:0] baseaddr;
    logic [15:0]      hactive;
    logic [15:0]      vactive;
    logic [CSIZE-1:0] dir_fifo, rnd_fifo, fifo_count;
    logic             dir_ready, rnd_ready, req_ready;
    logic             rand_mode, auto_done, man_done;
    logic             req_valid  [2];
    logic [ASIZE-1:0] req_addr   [2];
    logic [LSIZE-1:0] req_len    [2];
    logic             busy       [2];
    logic             frame_done [2];
    logic             done_r     [2];

    assign fifo_count = rand_mode ? rnd_fifo  : dir_fifo;
    assign req_ready  = rand_mode ? rnd_ready : dir_ready;

    rd_burst_planner #(.BURST_LEN(BL0)) u_dut64 (
        .axi_aclk(clk), .axi_resetn(rst_n), .enable(enable), .fsync(fsync),
        .baseaddr(baseaddr), .hactive(hactive), .vactive(vactive),
        .fifo_count(fifo_count), .req_valid(req_valid[0]), .req_ready(req_ready),
        .req_addr(req_addr[0]), .req_len(req_len[0]), .req_done(done_r[0] | man_done),
        .busy(busy[0]), .frame_done(frame_done[0]));

    rd_burst_planner #(.BURST_LEN(BL1)) u_dut200 (
        .axi_aclk(clk), .axi_resetn(rst_n), .enable(enable), .fsync(fsync),
        .baseaddr(baseaddr), .hactive(hactive), .vactive(vactive),
        .fifo_count(fifo_count), .req_valid(req_valid[1]), .req_ready(req_ready),
        .req_addr(req_addr[1]), .req_len(req_len[1]), .req_done(done_r[1] | man_done),
        .busy(busy[1]), .frame_done(frame_done[1]));

    int   checks = 0;
    int   errors = 0;
    req_t log_q[$];
    int   dly_cnt [2];
    int   fd_cnt  [2];
    int   done_dly;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Inputs settle 2 units after each rising edge; the negedge sees what the next edge takes.
    initial begin
        req_t r;
        done_r[0] = 1'b0; done_r[1] = 1'b0;
        dly_cnt[0] = 0; dly_cnt[1] = 0; fd_cnt[0] = 0; fd_cnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                done_r[g] = 1'b0;
                if (fsync || !rst_n) begin
                    dly_cnt[g] = 0;
                    fd_cnt[g]  = 0;
                end else begin
                    if (frame_done[g]) fd_cnt[g]++;
                    if (req_valid[g] && req_ready) begin
                        r.inst = 1'(g); r.addr = req_addr[g]; r.len = req_len[g];
                        log_q.push_back(r);
                        dly_cnt[g] = rand_mode ? int'($urandom_range(1, 6)) : done_dly;
                    end else if (dly_cnt[g] > 0) begin
                        dly_cnt[g]--;
                        if (dly_cnt[g] == 0 && auto_done) done_r[g] = 1'b1;
                    end
                end
            end
            if (fsync || !rst_n) log_q.delete();
        end
    end

    initial begin
        rnd_fifo  = '0;
        rnd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            rnd_fifo  = CSIZE'($urandom_range(0, 350));
            rnd_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic int n_req(input int g);
        int n = 0;
        foreach (log_q[i]) if (log_q[i].inst == 1'(g)) n++;
        return n;
    endfunction

    task automatic start_frame(input logic [ASIZE-1:0] b, input int h, input int v);
        baseaddr = b;
        hactive  = 16'(h);
        vactive  = 16'(v);
        fsync    = 1'b1;
        cyc(1);
        fsync    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while ((busy[0] || busy[1]) && i < 6000) begin
            cyc(1);
            i++;
        end
        check_eq({tag, "_idle"}, 64'(busy[0] || busy[1]), 64'(0));
    endtask

    task automatic wait_nreq(input int g, input int n, input string tag);
        int i = 0;
        while (n_req(g) < n && i < 200) begin
            cyc(1);
            i++;
        end
        check_eq(tag, 64'(n_req(g)), 64'(n));
    endtask

    // Reference: each line starts LINE_STRIDE after the previous one and is
    // cut into BURST_LEN pieces plus a tail; addresses wrap at 2^ASIZE.
    task automatic cmp_frame(input string tag, input int g, input int bl,
                             input logic [ASIZE-1:0] b, input int h, input int v);
        req_t             exp_q[$];
        req_t             got_q[$];
        req_t             r;
        int               beats, left, len;
        logic [ASIZE-1:0] a;
        beats = (h * 24 + 255) / 256;
        if (h != 0 && v != 0) begin
            for (int ln = 0; ln < v; ln++) begin
                a    = b + ASIZE'(ln * 8192);
                left = beats;
                while (left > 0) begin
                    len    = (left < bl) ? left : bl;
                    r.inst = 1'(g); r.addr = a; r.len = LSIZE'(len);
                    exp_q.push_back(r);
                    a    = a + ASIZE'(len * 32);
                    left = left - len;
                end
            end
        end
        foreach (log_q[i]) if (log_q[i].inst == 1'(g)) got_q.push_back(log_q[i]);
        check_eq({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), 64'(got_q[i].addr), 64'(exp_q[i].addr));
            check_eq($sformatf("%s_len%0d", tag, i), 64'(got_q[i].len), 64'(exp_q[i].len));
        end
        check_eq({tag, "_fdone"}, 64'(fd_cnt[g]), 64'(1));
    endtask

    task automatic cmp_both(input string tag, input logic [ASIZE-1:0] b, input int h, input int v);
        cmp_frame({tag, "64"}, 0, BL0, b, h, v);
        cmp_frame({tag, "200"}, 1, BL1, b, h, v);
    endtask

    initial begin
        logic             seen, stable;
        logic [ASIZE-1:0] h_addr, b;
        logic [LSIZE-1:0] h_len;
        int               h, v;
        rst_n = 1'b0; enable = 1'b1; fsync = 1'b0; baseaddr = '0; hactive = '0; vactive = '0;
        dir_fifo = '0; dir_ready = 1'b1; rand_mode = 1'b0; auto_done = 1'b1; man_done = 1'b0;
        done_dly = 5;
        cyc(3);
        check_eq("rst_valid", 64'(req_valid[0]), 64'(0));
        check_eq("rst_addr", 64'(req_addr[0]), 64'(0));
        check_eq("rst_len", 64'(req_len[0]), 64'(0));
        check_eq("rst_busy", 64'(busy[0]), 64'(0));
        check_eq("rst_fdone", 64'(frame_done[0]), 64'(0));
        check_eq("rst_valid200", 64'(req_valid[1]), 64'(0));
        rst_n = 1'b1;
        cyc(2);

        // basic line split
        start_frame(ASIZE'(32'h0100_0000), 1920, 2);
        wait_idle("basic");
        cmp_both("basic", ASIZE'(32'h0100_0000), 1920, 2);

        // back-pressure, including the exact-fit boundary
        dir_fifo = CSIZE'(460);
        start_frame(ASIZE'(32'h0100_0000), 1920, 2);
        seen = 1'b0;
        repeat (6) begin cyc(1); if (req_valid[0]) seen = 1'b1; end
        dir_fifo = CSIZE'(448);
        repeat (4) begin cyc(1); if (req_valid[0]) seen = 1'b1; end
        check_eq("bp_hold", 64'(seen), 64'(0));
        dir_fifo = CSIZE'(447);
        cyc(1);
        check_eq("bp_release", 64'(req_valid[0]), 64'(1));
        check_eq("bp_stall200", 64'(req_valid[1]), 64'(0));
        dir_fifo = '0;
        wait_idle("bp");
        cmp_both("bp", ASIZE'(32'h0100_0000), 1920, 2);

        // handshake hold
        dir_ready = 1'b0;
        start_frame(ASIZE'(32'h0040_0000), 1920, 2);
        wait_nreq(0, 0, "hs_noreq");
        for (int i = 0; i < 20 && !req_valid[0]; i++) cyc(1);
        check_eq("hs_valid", 64'(req_valid[0]), 64'(1));
        h_addr = req_addr[0]; h_len = req_len[0]; stable = 1'b1;
        repeat (10) begin
            cyc(1);
            if (!req_valid[0] || req_addr[0] != h_addr || req_len[0] != h_len) stable = 1'b0;
        end
        check_eq("hs_stable", 64'(stable), 64'(1));
        check_eq("hs_addr", 64'(h_addr), 64'(32'h0040_0000));
        check_eq("hs_len", 64'(h_len), 64'(64));
        dir_ready = 1'b1;
        cyc(2);
        check_eq("hs_one_req", 64'(n_req(0)), 64'(1));
        wait_idle("hs");
        cmp_both("hs", ASIZE'(32'h0040_0000), 1920, 2);

        // abort: frame start coincident with completion of burst 2
        auto_done = 1'b0;
        start_frame(ASIZE'(32'h0100_0000), 1920, 2);
        wait_nreq(0, 1, "abort_req1");
        cyc(2);
        man_done = 1'b1; cyc(1); man_done = 1'b0;
        wait_nreq(0, 2, "abort_req2");
        cyc(2);
        man_done  = 1'b1;
        auto_done = 1'b1;
        start_frame(ASIZE'(32'h0200_0000), 1920, 2);
        man_done  = 1'b0;
        wait_idle("abort");
        cmp_both("abort", ASIZE'(32'h0200_0000), 1920, 2);

        // degenerate geometry
        start_frame(ASIZE'(32'h0300_0000), 0, 2);
        check_eq("deg_busy", 64'(busy[0]), 64'(1));
        check_eq("deg_fd_c1", 64'(frame_done[0]), 64'(0));
        cyc(1);
        check_eq("deg_fd_c2", 64'(frame_done[0]), 64'(1));
        cyc(1);
        check_eq("deg_fd_c3", 64'(frame_done[0]), 64'(0));
        check_eq("deg_idle", 64'(busy[0]), 64'(0));
        check_eq("deg_noreq", 64'(n_req(0) + n_req(1)), 64'(0));

        // enable low holds the frame
        enable = 1'b0;
        start_frame(ASIZE'(32'h0080_0000), 640, 3);
        seen = 1'b0;
        repeat (10) begin cyc(1); if (req_valid[0] || req_valid[1]) seen = 1'b1; end
        check_eq("en_noreq", 64'(seen), 64'(0));
        check_eq("en_busy", 64'(busy[0] && busy[1]), 64'(1));
        enable = 1'b1;
        cyc(1);
        check_eq("en_release", 64'(req_valid[0]), 64'(1));
        wait_idle("en");
        cmp_both("en", ASIZE'(32'h0080_0000), 640, 3);

        // address wrap
        start_frame(ASIZE'(32'h1FFF_F800), 1920, 2);
        wait_idle("wrap");
        cmp_both("wrap", ASIZE'(32'h1FFF_F800), 1920, 2);

        // asynchronous reset mid-burst
        start_frame(ASIZE'(32'h0100_0000), 1920, 2);
        for (int i = 0; i < 20 && !req_valid[0]; i++) cyc(1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 64'(req_valid[0]), 64'(0));
        check_eq("arst_busy", 64'(busy[0]), 64'(0));
        check_eq("arst_addr", 64'(req_addr[0]), 64'(0));
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // randomized frames with random FIFO level, ready and completion delay
        rand_mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            b = ASIZE'($urandom);
            h = int'($urandom_range(1, 2400));
            if ($urandom_range(0, 7) == 0) h = 0;
            v = int'($urandom_range(0, 3));
            start_frame(b, h, v);
            wait_idle($sformatf("rnd%0d", k));
            cmp_both($sformatf("rnd%0d_", k), b, h, v);
        end
        rand_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rd_burst_planner.md
Name: rd_burst_planner

Overview:
- Read-side request planner for the VDMA, running in the AXI clock domain.
- Sits directly upstream of the AXI read state core. It turns a frame start, the active video geometry and the stream-FIFO write count into a sequence of burst requests: one address and one length per request.
- Each line is split into full bursts plus one tail burst. The line address advances by a fixed stride.
- A burst is issued only when the stream FIFO has room for all of it.

Parameters:
- ASIZE, 29, AXI address width.
- LSIZE, 9, request-length width. Must hold BURST_LEN.
- BURST_LEN, 200, maximum beats per burst. Range 1..2^LSIZE-1.
- FULL_LEN, 512, stream FIFO depth in AXI beats.
- CSIZE, 10, FIFO count width.
- AXI_DSIZE, 256, AXI data width in bits. Must be a power of two.
- DSIZE, 24, pixel width in bits.
- LINE_STRIDE, 8192, byte address step between line starts.

Ports:
- axi_aclk  in  1  clock.
- axi_resetn  in  1  asynchronous active-low reset.
- enable  in  1  level. Permits new requests.
- fsync  in  1  single-cycle frame start, already synchronised to axi_aclk.
- baseaddr  in  ASIZE  frame byte base. Sampled on fsync.
- hactive  in  16  pixels per line. Sampled on fsync.
- vactive  in  16  lines per frame. Sampled on fsync.
- fifo_count  in  CSIZE  stream FIFO write-side data count.
- req_valid  out  1  burst request valid.
- req_ready  in  1  request accepted.
- req_addr  out  ASIZE  burst start byte address.
- req_len  out  LSIZE  burst length in beats, 1..BURST_LEN. The downstream core subtracts 1 to form arlen.
- req_done  in  1  single-cycle pulse: last beat of the accepted burst has been received.
- busy  out  1  a frame is in progress.
- frame_done  out  1  single-cycle pulse after the last burst of the frame completes.

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. All counters and addresses clear.
- Line beats:
  - line_beats = ceil(hactive*DSIZE / AXI_DSIZE).
  - Computed as (hactive*DSIZE + AXI_DSIZE-1) >> log2(AXI_DSIZE), using a 32-bit intermediate.
  - Registered one cycle after fsync.
- Beat bytes: BB = AXI_DSIZE/8. All address arithmetic wraps modulo 2^ASIZE.
- cur_len = min(BURST_LEN, beats_left).
- FSM states: IDLE, CALC, WAIT_SPACE, REQ, WAIT_DONE, FRAME_END.
- fsync handling:
  - fsync has top priority in every state.
  - It latches the geometry, sets line_addr and addr to baseaddr, sets line_cnt to 0, and goes to CALC.
  - req_valid drops on the same edge. The downstream core is flushed by the same frame start.
- CALC (1 cycle):
  - beats_left = line_beats.
  - If hactive==0 or vactive==0, go to FRAME_END.
  - Otherwise go to WAIT_SPACE.
- WAIT_SPACE:
  - Go to REQ when enable==1 and (FULL_LEN - fifo_count) > cur_len. The comparison is strict to keep a one-beat margin.
  - With enable==0, stay here; a burst already accepted still completes.
- REQ:
  - req_valid=1, req_addr=addr, req_len=cur_len. All three are registered outputs and stay stable until req_ready.
  - On req_valid && req_ready, req_valid drops next cycle and the FSM goes to WAIT_DONE.
- WAIT_DONE: on req_done:
  - addr += cur_len*BB.
  - beats_left -= cur_len.
  - If beats_left becomes 0:
    - line_cnt++.
    - line_addr += LINE_STRIDE, and addr takes the new line_addr.
    - beats_left reloads to line_beats.
    - If line_cnt reaches vactive, go to FRAME_END; otherwise go to WAIT_SPACE.
  - Otherwise go to WAIT_SPACE.
  - req_done outside WAIT_DONE is ignored.
- FRAME_END: frame_done=1 for one cycle, then IDLE.
- busy is 1 in every state except IDLE.
- Only one burst is ever outstanding. A new request is never issued before req_done.
- fsync and req_done in the same cycle: fsync wins and the completion is discarded.
- An asynchronous reset mid-burst returns everything to reset values immediately.

Decomposition:
- Package rd_burst_pkg holds:
  - state enum typedef;
  - function ceil_beats(hactive, DSIZE, AXI_DSIZE);
  - constant BB.
- One sub-module, burst_len_splitter: holds beats_left, computes cur_len, and reloads per line.
- The FSM and address registers stay in the top module.

Test Plan:
- Basic line split:
  - Setup: BURST_LEN=64, hactive=1920, vactive=2, baseaddr=0x0100_0000, fifo_count=0, req_ready tied 1, req_done 5 cycles after accept.
  - Expect: 6 requests, addr/len = 0x0100_0000/64, 0x0100_0800/64, 0x0100_1000/52, 0x0100_2000/64, 0x0100_2800/64, 0x0100_3000/52.
  - Expect: then one frame_done pulse, and busy low.
- Back-pressure: fifo_count=460 with cur_len=64 → no req_valid; drop fifo_count to 447 → req_valid the next cycle.
- Handshake hold: req_ready low for 10 cycles → req_valid, req_addr and req_len stable throughout; exactly one request counted.
- Abort: fsync in WAIT_DONE of burst 2, with req_done coincident → completion ignored; next request is at the new baseaddr with len 64.
- Degenerate: hactive=0 → no req_valid; frame_done exactly 2 cycles after fsync. Also: enable=0 after fsync → busy=1, no request until enable rises.
- Address wrap: baseaddr=0x1FFF_F800, BURST_LEN=200 with hactive=1920 → first request 0x1FFF_F800 len 180; second line's first request at 0x0000_1800.
